// File: rtl/fp_gt_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters, the shared fp_gt arbiter
// and the response consumer.
interface fp_gt_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] f1_bus;
   logic [NUM_REQ*WIDTH-1:0] f2_bus;
   logic [NUM_REQ-1:0]       gnt;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic                     rsp_result;
   logic [1:0]               rsp_id;
   logic                     busy;

   modport master (
      output req, f1_bus, f2_bus, rsp_ready,
      input  gnt, rsp_valid, rsp_result, rsp_id, busy
   );

   modport slave (
      input  req, f1_bus, f2_bus, rsp_ready,
      output gnt, rsp_valid, rsp_result, rsp_id, busy
   );
endinterface

// File: rtl/fp_gt_arbiter.sv
// Round-robin arbiter sharing one IEEE-754 single-precision greater-than
// comparator between NUM_REQ requesters, with a held response register.

module fp_gt #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_gt
);
   logic w_a_nan;
   logic w_b_nan;
   logic w_both_zero;

   assign w_a_nan     = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
   assign w_b_nan     = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
   assign w_both_zero = (i_a[30:0] == 31'd0) && (i_b[30:0] == 31'd0);

   // NaN is unordered and +0 equals -0, so neither is ever "greater"
   always_comb begin
      o_gt = 1'b0;
      if (!w_a_nan && !w_b_nan && !w_both_zero) begin
         case ({i_a[31], i_b[31]})
            2'b00:   o_gt = (i_a[30:0] > i_b[30:0]);
            2'b01:   o_gt = 1'b1;
            2'b10:   o_gt = 1'b0;
            default: o_gt = (i_a[30:0] < i_b[30:0]);
         endcase
      end
   end
endmodule

// state | meaning
// ARB   | idle / arbitrate; grant when a request is pending and the response slot is free
// CMP   | one cycle: gnt high, compare latched operands, write the response register
module fp_gt_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
) (
   input logic            clk,
   input logic            rst_n,
   fp_gt_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic {ARB = 1'b0, CMP = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDW-1:0]     r_last;
   logic [IDW-1:0]     r_id;
   logic [IDW-1:0]     r_rsp_id;
   logic [WIDTH-1:0]   r_f1;
   logic [WIDTH-1:0]   r_f2;
   logic [NUM_REQ-1:0] r_gnt;
   logic               r_rsp_valid;
   logic               r_rsp_result;
   logic [IDW-1:0]     w_win;
   logic [IDW-1:0]     w_cand;
   logic               w_found;
   logic               w_fire;
   logic               w_gt;
   logic [WIDTH-1:0]   w_f1_sel;
   logic [WIDTH-1:0]   w_f2_sel;

   // Search starts one past the last grant and wraps through the index space
   always_comb begin
      w_win   = '0;
      w_cand  = '0;
      w_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = r_last + IDW'(k);
         if (!w_found && bus.req[w_cand]) begin
            w_win   = w_cand;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_f1_sel = '0;
      w_f2_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == IDW'(i)) begin
            w_f1_sel = bus.f1_bus[i*WIDTH +: WIDTH];
            w_f2_sel = bus.f2_bus[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fire      = 1'b0;
      case (r_state)
         ARB: begin
            if (w_found && (!r_rsp_valid || bus.rsp_ready)) begin
               w_fire      = 1'b1;
               w_state_nxt = CMP;
            end
         end
         CMP:     w_state_nxt = ARB;
         default: w_state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ARB;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last       <= IDW'(NUM_REQ - 1);
         r_id         <= '0;
         r_f1         <= '0;
         r_f2         <= '0;
         r_gnt        <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= 1'b0;
         r_rsp_id     <= '0;
      end else begin
         r_gnt <= '0;
         if (w_fire) begin
            r_f1   <= w_f1_sel;
            r_f2   <= w_f2_sel;
            r_id   <= w_win;
            r_last <= w_win;
            r_gnt  <= NUM_REQ'(1) << w_win;
         end
         if (r_state == CMP) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= w_gt;
            r_rsp_id     <= r_id;
         end else if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   fp_gt #(.WIDTH(WIDTH)) u_fp_gt (
      .i_a  (r_f1),
      .i_b  (r_f2),
      .o_gt (w_gt)
   );

   assign bus.gnt        = r_gnt;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_id     = r_rsp_id;
   assign bus.busy       = (r_state != ARB) || r_rsp_valid;
endmodule

// File: tb/tb_fp_gt_arbiter.sv
// Bench for fp_gt_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model using real-valued float comparison.
module tb_fp_gt_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fp_gt_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
   fp_gt_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_assert = 0;
   int n_fail   = 0;

   // model state
   int         m_last;
   bit         m_cmp;
   bit         m_pend;
   bit         m_res;
   int         m_id;
   bit         m_op_gt;
   int         m_op_id;
   logic [N-1:0] m_gnt;
   bit         hold_req;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic real f2r(input logic [31:0] b);
      int  e;
      real m;
      real v;
      e = int'(b[30:23]);
      m = real'(b[22:0]);
      if (e == 0) v = m * (2.0 ** (-149));
      else        v = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
      return b[31] ? -v : v;
   endfunction

   function automatic bit ref_gt(input logic [31:0] a, input logic [31:0] b);
      return f2r(a) > f2r(b);
   endfunction

   function automatic int rr_pick(input int last, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0:       v = {$urandom_range(0, 1) == 1, 31'd0};
         1:       v = {$urandom_range(0, 1) == 1, 8'($urandom_range(0, 254)), 23'($urandom)};
         default: v = {$urandom_range(0, 1) == 1, 8'($urandom_range(124, 131)), 23'($urandom)};
      endcase
      return v;
   endfunction

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      bus.f1_bus[i*W +: W] = a;
      bus.f2_bus[i*W +: W] = b;
   endtask

   task automatic set_rnd_op(input int i);
      logic [31:0] a;
      logic [31:0] b;
      a = rnd_fp();
      case ($urandom_range(0, 3))
         0:       b = a;
         1:       b = a ^ 32'h8000_0000;
         default: b = rnd_fp();
      endcase
      set_op(i, a, b);
   endtask

   task automatic model_reset();
      m_last = N - 1;
      m_cmp  = 1'b0;
      m_pend = 1'b0;
      m_gnt  = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_result", bus.rsp_result, 0);
      chk("rst_id", bus.rsp_id, 0);
      chk("rst_busy", bus.busy, 0);
      #1;
      rst_n = 1'b1;
   endtask

   // One clock: advance the model on the inputs seen at the edge, then compare
   task automatic cycle();
      logic [N-1:0]   s_req;
      bit             s_ready;
      logic [N*W-1:0] s_f1;
      logic [N*W-1:0] s_f2;
      bit             can;
      int             w;
      s_req   = bus.req;
      s_ready = bus.rsp_ready;
      s_f1    = bus.f1_bus;
      s_f2    = bus.f2_bus;
      @(posedge clk);
      #1;
      m_gnt = '0;
      if (m_cmp) begin
         m_cmp  = 1'b0;
         m_pend = 1'b1;
         m_res  = m_op_gt;
         m_id   = m_op_id;
      end else begin
         can = !m_pend || s_ready;
         if (m_pend && s_ready) m_pend = 1'b0;
         if (s_req != '0 && can) begin
            w        = rr_pick(m_last, s_req);
            m_last   = w;
            m_cmp    = 1'b1;
            m_gnt[w] = 1'b1;
            m_op_id  = w;
            m_op_gt  = ref_gt(s_f1[w*W +: W], s_f2[w*W +: W]);
         end
      end
      chk("gnt", bus.gnt, m_gnt);
      chk("rsp_valid", bus.rsp_valid, m_pend);
      chk("busy", bus.busy, m_cmp || m_pend);
      if (m_pend) begin
         chk("rsp_result", bus.rsp_result, m_res);
         chk("rsp_id", bus.rsp_id, m_id);
      end
      if (!hold_req) begin
         for (int i = 0; i < N; i++) begin
            if (bus.gnt[i]) begin
               bus.req[i] = 1'b0;
               set_rnd_op(i);
            end
         end
      end
   endtask

   task automatic single(input int i, input logic [31:0] a, input logic [31:0] b,
                         input bit exp_res, input string tag);
      set_op(i, a, b);
      bus.req = '0;
      bus.req[i] = 1'b1;
      cycle();
      chk({tag, "_gnt"}, bus.gnt, 32'd1 << i);
      cycle();
      chk({tag, "_valid"}, bus.rsp_valid, 1);
      chk({tag, "_result"}, bus.rsp_result, exp_res);
      chk({tag, "_id"}, bus.rsp_id, i);
      cycle();
      chk({tag, "_accepted"}, bus.rsp_valid, 0);
   endtask

   initial begin
      logic [N-1:0] rr_exp [10];
      rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
      hold_req      = 1'b0;
      bus.req       = '0;
      bus.rsp_ready = 1'b1;
      bus.f1_bus    = '0;
      bus.f2_bus    = '0;
      rst_n         = 1'b0;
      #12;
      do_reset();

      single(0, 32'h41400000, 32'hC1400000, 1'b1, "pos_vs_neg");
      single(2, 32'hC20A3D71, 32'hC16570A4, 1'b0, "neg_neg");
      single(2, 32'hC16570A4, 32'hC20A3D71, 1'b1, "neg_neg_swap");
      single(1, 32'h00000000, 32'hC123AE14, 1'b1, "zero_vs_neg");
      single(3, 32'h00000000, 32'h41566666, 1'b0, "zero_vs_pos");

      // fairness with every request held continuously
      #2;
      do_reset();
      hold_req = 1'b1;
      for (int i = 0; i < N; i++) set_rnd_op(i);
      bus.req = '1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk($sformatf("rr_gnt_%0d", k), bus.gnt, rr_exp[k]);
      end
      hold_req = 1'b0;
      bus.req  = '0;
      cycle();

      // backpressure
      #2;
      do_reset();
      bus.rsp_ready = 1'b0;
      set_op(0, 32'h41C47AE1, 32'h4123AE14);
      set_rnd_op(1);
      bus.req = 4'b0011;
      cycle();
      chk("bp_gnt0", bus.gnt, 4'b0001);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("bp_hold_valid", bus.rsp_valid, 1);
         chk("bp_hold_result", bus.rsp_result, 1);
         chk("bp_hold_id", bus.rsp_id, 0);
         chk("bp_hold_gnt", bus.gnt, 0);
      end
      bus.rsp_ready = 1'b1;
      cycle();
      chk("bp_gnt1", bus.gnt, 4'b0010);
      chk("bp_accepted", bus.rsp_valid, 0);
      cycle();
      chk("bp_rsp1_id", bus.rsp_id, 1);
      cycle();

      // reset pulse during CMP
      for (int i = 0; i < N; i++) set_rnd_op(i);
      bus.req = '1;
      cycle();
      chk("mid_gnt", bus.gnt, 4'b0100);
      bus.req = '0;
      #1;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("post_rst_gnt", bus.gnt, 0);
         chk("post_rst_valid", bus.rsp_valid, 0);
      end
      bus.req = '1;
      cycle();
      chk("post_rst_first", bus.gnt, 4'b0001);
      bus.req = '0;
      cycle();
      cycle();

      // random traffic
      for (int c = 0; c < 2000; c++) begin
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
               set_rnd_op(i);
               bus.req[i] = 1'b1;
            end
         end
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
